// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Branch resolution stage: evaluates the branch condition on the operand
// pair, compares it against the fetch-time prediction, and holds the result
// in a single output register behind a valid/ready handshake. It also owns
// the 2-bit saturating direction table read by fetch, plus saturating
// resolved-branch and mispredict statistics.
module branch_resolve_unit #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       branch,
  input  logic [PC_W-1:0]  pc,
  input  logic [WIDTH-1:0] bus_a,
  input  logic [WIDTH-1:0] bus_b,
  input  logic             pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             mispredict,
  output logic [PC_W-1:0]  out_pc,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             lookup_taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BGEZ = 4'd3,
    OP_BGTZ = 4'd4,
    OP_BLEZ = 4'd5,
    OP_BLTZ = 4'd6,
    OP_BLTU = 4'd7,
    OP_BGEU = 4'd8
  } br_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q;
  logic             taken_q;
  logic             mispredict_q;
  logic [PC_W-1:0]  out_pc_q;
  logic             is_br_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       ctr_q [DEPTH];
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] mp_count_q;

  logic             cond_d;
  logic             is_br_d;
  logic             a_neg;
  logic             a_zero;
  logic             in_fire;
  logic             out_fire;
  logic [IDX_W-1:0] in_idx;
  logic [IDX_W-1:0] lookup_idx;
  logic             unused_lookup_bits;

  assign a_neg  = bus_a[WIDTH-1];
  assign a_zero = (bus_a == '0);

  // Branch condition on the raw request operands; unknown ops never take.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    cond_d = 1'b0;
    case (branch)
      OP_BEQ:  cond_d = (bus_a == bus_b);
      OP_BNE:  cond_d = (bus_a != bus_b);
      OP_BGEZ: cond_d = !a_neg;
      OP_BGTZ: cond_d = !a_neg && !a_zero;
      OP_BLEZ: cond_d = a_neg || a_zero;
      OP_BLTZ: cond_d = a_neg;
      OP_BLTU: cond_d = (bus_a < bus_b);
      OP_BGEU: cond_d = (bus_a >= bus_b);
      default: cond_d = 1'b0;
    endcase
  end

  assign is_br_d  = (branch >= OP_BEQ) && (branch <= OP_BGEU);
  assign in_idx   = pc[IDX_W+1:2];

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Output register FSM: EMPTY/FULL with the result fields held while FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      out_pc_q     <= '0;
      is_br_q      <= 1'b0;
      idx_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) state_q <= ST_FULL;
        end
        ST_FULL: begin
          if (out_fire && !in_fire) state_q <= ST_EMPTY;
        end
        default: state_q <= ST_EMPTY;
      endcase
      if (in_fire) begin
        taken_q      <= cond_d;
        mispredict_q <= cond_d ^ pred_taken;
        out_pc_q     <= pc;
        is_br_q      <= is_br_d;
        idx_q        <= in_idx;
      end
    end
  end

  // Direction table: one saturating step per retiring branch result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is flop-based and must come out of reset weakly
      // not-taken, so every entry is reset explicitly rather than left as RAM.
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
    end else if (out_fire && is_br_q) begin
      if (taken_q) begin
        if (ctr_q[idx_q] != 2'b11) ctr_q[idx_q] <= ctr_q[idx_q] + 2'd1;
      end else begin
        if (ctr_q[idx_q] != 2'b00) ctr_q[idx_q] <= ctr_q[idx_q] - 2'd1;
      end
    end
  end

  // Statistics: count retiring branches and their mispredicts, never wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else if (out_fire && is_br_q) begin
      if (br_count_q != '1) br_count_q <= br_count_q + CNT_W'(1);
      if (mispredict_q && (mp_count_q != '1)) mp_count_q <= mp_count_q + CNT_W'(1);
    end
  end

  // Fetch-side read is combinational; a same-cycle update shows next cycle.
  assign lookup_idx   = lookup_pc[IDX_W+1:2];
  assign lookup_taken = ctr_q[lookup_idx][1];

  // Only the index field of the lookup address selects an entry.
  assign unused_lookup_bits = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

  assign taken      = taken_q;
  assign mispredict = mispredict_q;
  assign out_pc     = out_pc_q;
  assign br_count   = br_count_q;
  assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit. A transaction-level model
// (integer counters, clamped arithmetic) tracks the expected result register,
// direction table and statistics; two instances share stimulus so that the
// narrow-counter saturation behaviour is observed alongside the default one.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  branch;
  logic [31:0] pc;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic        pred_taken;
  logic        out_ready;
  logic [31:0] lookup_pc;

  logic        in_ready, out_valid, taken, mispredict, lookup_taken;
  logic [31:0] out_pc;
  logic [15:0] br_count, mp_count;

  logic        in_ready_s, out_valid_s, taken_s, mispredict_s, lookup_taken_s;
  logic [31:0] out_pc_s;
  logic [1:0]  br_count_s, mp_count_s;

  int checks   = 0;
  int failures = 0;

  // Model state
  bit          m_valid;
  bit          m_taken;
  bit          m_mp;
  logic [31:0] m_pc;
  bit          m_isbr;
  int          m_idx;
  int          m_ctr [16];
  int          m_br;
  int          m_mpc;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .branch(branch), .pc(pc), .bus_a(bus_a), .bus_b(bus_b),
    .pred_taken(pred_taken), .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .mispredict(mispredict), .out_pc(out_pc),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .br_count(br_count), .mp_count(mp_count)
  );

  branch_resolve_unit #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .branch(branch), .pc(pc), .bus_a(bus_a), .bus_b(bus_b),
    .pred_taken(pred_taken), .out_valid(out_valid_s), .out_ready(out_ready),
    .taken(taken_s), .mispredict(mispredict_s), .out_pc(out_pc_s),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken_s),
    .br_count(br_count_s), .mp_count(mp_count_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_cond(input int op, input logic [31:0] a, input logic [31:0] b);
    int signed sa;
    sa = a;
    case (op)
      1: return a == b;
      2: return a != b;
      3: return sa >= 0;
      4: return sa > 0;
      5: return sa <= 0;
      6: return sa < 0;
      7: return a < b;
      8: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic int lidx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_taken = 0; m_mp = 0; m_pc = '0; m_isbr = 0; m_idx = 0;
    m_br = 0; m_mpc = 0;
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".out_valid"}, out_valid, m_valid);
    check({ctx, ".in_ready"}, in_ready, !m_valid || out_ready);
    if (m_valid) begin
      check({ctx, ".taken"}, taken, m_taken);
      check({ctx, ".mispredict"}, mispredict, m_mp);
      check({ctx, ".out_pc"}, out_pc, m_pc);
    end
    check({ctx, ".br_count"}, br_count, sat(m_br, 65535));
    check({ctx, ".mp_count"}, mp_count, sat(m_mpc, 65535));
    check({ctx, ".br_count_w2"}, br_count_s, sat(m_br, 3));
    check({ctx, ".mp_count_w2"}, mp_count_s, sat(m_mpc, 3));
    check({ctx, ".lookup_taken"}, lookup_taken, m_ctr[lidx(lookup_pc)] >= 2);
  endtask

  // Advance one clock: decide what fires from pre-edge inputs, apply to the
  // model, then compare everything just after the edge.
  task automatic cycle(input string ctx);
    bit          in_fire, out_fire, c, nb;
    logic [31:0] p;
    in_fire  = in_valid && (!m_valid || out_ready);
    out_fire = m_valid && out_ready;
    c  = ref_cond(int'(branch), bus_a, bus_b) ^ 1'b0;
    nb = (branch >= 1) && (branch <= 8);
    p  = pc;
    @(posedge clk);
    #1;
    if (out_fire && m_isbr) begin
      m_ctr[m_idx] = m_taken ? ((m_ctr[m_idx] < 3) ? m_ctr[m_idx] + 1 : 3)
                             : ((m_ctr[m_idx] > 0) ? m_ctr[m_idx] - 1 : 0);
      m_br++;
      if (m_mp) m_mpc++;
    end
    if (in_fire) begin
      m_valid = 1; m_taken = c; m_mp = c ^ pred_taken; m_pc = p;
      m_isbr = nb; m_idx = lidx(p);
    end else if (out_fire) begin
      m_valid = 0;
    end
    compare_all(ctx);
  endtask

  task automatic drive(input bit v, input int op, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input bit pt);
    in_valid = v; branch = 4'(op); pc = p; bus_a = a; bus_b = b; pred_taken = pt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.taken", taken, 1'b0);
    check("rst.mispredict", mispredict, 1'b0);
    check("rst.out_pc", out_pc, 32'h0);
    check("rst.br_count", br_count, 16'h0);
    check("rst.mp_count", mp_count, 16'h0);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'(i << 2);
      #1;
      check("rst.lookup_taken", lookup_taken, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; lookup_pc = '0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    do_reset();

    // Basic BEQ taken, predicted not-taken
    @(posedge clk); #1;
    drive(1, 1, 32'h100, 32'h5, 32'h5, 0);
    lookup_pc = 32'h100;
    cycle("beq");
    check("beq.taken", taken, 1'b1);
    check("beq.mispredict", mispredict, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    cycle("beq_retire");
    check("beq.br_count", br_count, 16'd1);
    check("beq.lookup_new", lookup_taken, 1'b1);

    // Signed vs unsigned condition evaluation
    drive(1, 6, 32'h200, 32'hFFFF_FFFF, 32'h1, 0); cycle("bltz");
    check("bltz.taken", taken, 1'b1);
    drive(1, 7, 32'h204, 32'hFFFF_FFFF, 32'h1, 0); cycle("bltu");
    check("bltu.taken", taken, 1'b0);
    drive(1, 8, 32'h208, 32'hFFFF_FFFF, 32'h1, 0); cycle("bgeu");
    check("bgeu.taken", taken, 1'b1);
    drive(1, 4, 32'h20C, 32'hFFFF_FFFF, 32'h1, 0); cycle("bgtz");
    check("bgtz.taken", taken, 1'b0);
    drive(1, 5, 32'h210, 32'h0, 32'h1, 0); cycle("blez0");
    check("blez0.taken", taken, 1'b1);
    drive(1, 3, 32'h214, 32'h0, 32'h1, 0); cycle("bgez0");
    check("bgez0.taken", taken, 1'b1);
    drive(1, 0, 32'h218, 32'h0, 32'h0, 1); cycle("none_pred1");
    check("none.mispredict", mispredict, 1'b1);
    drive(1, 12, 32'h21C, 32'h3, 32'h3, 0); cycle("op12");
    check("op12.taken", taken, 1'b0);
    drive(0, 0, 0, 0, 0, 0); cycle("drain");

    // Backpressure: hold a BNE result, offer a second request meanwhile
    drive(1, 2, 32'h300, 32'h1, 32'h2, 0); cycle("bne");
    out_ready = 0;
    drive(1, 1, 32'h304, 32'h7, 32'h7, 1);
    for (int i = 0; i < 3; i++) cycle("stall");
    check("stall.out_pc", out_pc, 32'h300);
    check("stall.in_ready", in_ready, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1;
    cycle("release");
    cycle("release_idle");

    // Counter saturation on pc 0x40
    do_reset();
    lookup_pc = 32'h40;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h40, 32'h9, 32'h9, 1); cycle("sat_up");
    end
    drive(0, 0, 0, 0, 0, 0); cycle("sat_up_drain");
    check("sat_up.lookup", lookup_taken, 1'b1);
    check("sat_up.br_w2", br_count_s, 2'd3);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h40, 32'h9, 32'h8, 1); cycle("sat_dn");
    end
    drive(0, 0, 0, 0, 0, 0); cycle("sat_dn_drain");
    check("sat_dn.lookup", lookup_taken, 1'b0);
    check("sat.br_count", br_count, 16'd10);

    // Same-cycle lookup vs update on index 3
    do_reset();
    lookup_pc = 32'hC;
    out_ready = 0;
    drive(1, 1, 32'hC, 32'h1, 32'h1, 0); cycle("same_load");
    drive(0, 0, 0, 0, 0, 0);
    cycle("same_hold");
    out_ready = 1;
    #1;
    check("same.lookup_old", lookup_taken, 1'b0);
    cycle("same_update");
    check("same.lookup_new", lookup_taken, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom();
      if ($urandom_range(0, 7) == 0) a = '0;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15),
            {$urandom_range(0, 255), 2'b00}, a, b, 1'($urandom()));
      out_ready = ($urandom_range(0, 9) < 7);
      lookup_pc = $urandom();
      cycle("rand");
    end

    // Reset while FULL drops the held result
    out_ready = 0;
    drive(1, 1, 32'h44, 32'h2, 32'h2, 0); cycle("full_pre_rst");
    check("full_pre_rst.valid", out_valid, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1;
    do_reset();
    cycle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
